// File: rtl/aemb2_dwb_pkg.sv
// Shared types and constants for the AEMB2 data-bus return stage.
package aemb2_dwb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } dwb_state_e;

  localparam int CNT_W = 8;

  // Big-endian lane selects: B0 is the most significant byte.
  localparam logic [3:0] SEL_W   = 4'hF;
  localparam logic [3:0] SEL_HI  = 4'hC;
  localparam logic [3:0] SEL_LO  = 4'h3;
  localparam logic [3:0] SEL_B0  = 4'h8;
  localparam logic [3:0] SEL_B1  = 4'h4;
  localparam logic [3:0] SEL_B2  = 4'h2;
  localparam logic [3:0] SEL_B3  = 4'h1;
  localparam logic [3:0] SEL_XSL = 4'h0;

endpackage

// File: rtl/aemb2_ld_align.sv
// Right-aligns and zero-extends the selected lanes of a bus word.
module aemb2_ld_align
  import aemb2_dwb_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [31:0] dat,
  output logic [31:0] aligned
);

  // Unrecognised lane patterns return zero rather than partial data.
  always_comb begin
    aligned = 32'h0;
    case (sel)
      SEL_W:   aligned = dat;
      SEL_HI:  aligned = {16'h0, dat[31:16]};
      SEL_LO:  aligned = {16'h0, dat[15:0]};
      SEL_B0:  aligned = {24'h0, dat[31:24]};
      SEL_B1:  aligned = {24'h0, dat[23:16]};
      SEL_B2:  aligned = {24'h0, dat[15:8]};
      SEL_B3:  aligned = {24'h0, dat[7:0]};
      SEL_XSL: aligned = dat;
      default: aligned = 32'h0;
    endcase
  end

endmodule

// File: rtl/aemb2_dwb_rtn.sv
// Data-bus return stage: holds the pipeline during data cycles, captures
// aligned load data and aborts cycles that exceed the wait limit.
module aemb2_dwb_rtn
  import aemb2_dwb_pkg::*;
#(
  parameter int AEMB_DTO = 255
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        dwb_stb,
  input  logic        dwb_wre,
  input  logic [3:0]  dwb_sel,
  input  logic        dwb_ack_i,
  input  logic [31:0] dwb_dat_i,
  output logic        dwb_hold,
  output logic        dwb_abt,
  output logic [31:0] rdat_mx,
  output logic        rdat_vld,
  output logic        dwb_err
);

  localparam logic [CNT_W-1:0] DTO = CNT_W'(AEMB_DTO);

  dwb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      aligned;
  logic             done;
  logic             timeout;

  aemb2_ld_align u_align (
    .sel     (dwb_sel),
    .dat     (dwb_dat_i),
    .aligned (aligned)
  );

  // An ack only counts while an access is actually being presented.
  assign done    = dwb_ack_i & (((state == IDLE) & dwb_stb) | (state == WAIT));
  assign timeout = (state == WAIT) & ~dwb_ack_i & (cnt == DTO);

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dwb_hold  = 1'b0;
    case (state)
      IDLE: begin
        if (dwb_stb & ~dwb_ack_i) begin
          state_nxt = WAIT;
          dwb_hold  = 1'b1;
        end
      end
      WAIT: begin
        if (dwb_ack_i) begin
          state_nxt = IDLE;
        end else begin
          dwb_hold = 1'b1;
          if (cnt == DTO) state_nxt = ERR;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter saturates so an out-of-range limit can never wrap past it.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      cnt <= '0;
    end else if ((state == IDLE) & dwb_stb & ~dwb_ack_i) begin
      cnt <= CNT_W'(1);
    end else if ((state == WAIT) & ~dwb_ack_i & (cnt != DTO) & (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      rdat_mx  <= 32'h0;
      rdat_vld <= 1'b0;
    end else begin
      rdat_vld <= done & ~dwb_wre;
      if (done & ~dwb_wre) rdat_mx <= aligned;
      else if (timeout)    rdat_mx <= 32'h0;
    end
  end

  assign dwb_err = (state == ERR);
  assign dwb_abt = (state == ERR);

endmodule

// File: tb/tb_aemb2_dwb_rtn.sv
// Randomised scoreboard bench for the data-bus return stage.
module tb_aemb2_dwb_rtn;

  localparam int DTO = 4;

  logic        gclk = 1'b0;
  logic        grst;
  logic        dwb_stb, dwb_wre, dwb_ack_i;
  logic [3:0]  dwb_sel;
  logic [31:0] dwb_dat_i;
  logic        dwb_hold, dwb_abt, rdat_vld, dwb_err;
  logic [31:0] rdat_mx;

  typedef struct packed {
    logic        is_err;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_rdat;
  int          n_cmp = 0;
  int          n_bad = 0;

  aemb2_dwb_rtn #(.AEMB_DTO(DTO)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .dwb_stb   (dwb_stb),
    .dwb_wre   (dwb_wre),
    .dwb_sel   (dwb_sel),
    .dwb_ack_i (dwb_ack_i),
    .dwb_dat_i (dwb_dat_i),
    .dwb_hold  (dwb_hold),
    .dwb_abt   (dwb_abt),
    .rdat_mx   (rdat_mx),
    .rdat_vld  (rdat_vld),
    .dwb_err   (dwb_err)
  );

  always #5 gclk = ~gclk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference load result from the lane table, using shifts and masks.
  function automatic logic [31:0] exp_align(input logic [3:0] s, input logic [31:0] d);
    case (s)
      4'hF, 4'h0: return d;
      4'hC:       return d >> 16;
      4'h3:       return d & 32'h0000_FFFF;
      4'h8:       return d >> 24;
      4'h4:       return (d >> 16) & 32'hFF;
      4'h2:       return (d >> 8) & 32'hFF;
      4'h1:       return d & 32'hFF;
      default:    return 32'h0;
    endcase
  endfunction

  // wt = cycles before ack; wt > DTO means the slave never answers.
  task automatic run_txn(input bit wr, input logic [3:0] s, input logic [31:0] d, input int wt);
    bit to;
    to = (wt > DTO);
    if (to) begin
      ref_rdat = 32'h0;
      exp_q.push_back('{1'b1, 32'h0});
    end else if (!wr) begin
      ref_rdat = exp_align(s, d);
      exp_q.push_back('{1'b0, ref_rdat});
    end
    dwb_stb = 1'b1; dwb_wre = wr; dwb_sel = s; dwb_ack_i = 1'b0; dwb_dat_i = $urandom;
    for (int c = 0; c <= DTO && c <= wt; c++) begin
      if (c == wt) begin
        dwb_ack_i = 1'b1;
        dwb_dat_i = d;
      end
      @(negedge gclk);
      check_output("hold", 32'(dwb_hold), 32'(c != wt));
      @(posedge gclk); #1;
    end
    dwb_stb = 1'b0; dwb_ack_i = 1'b0; dwb_dat_i = $urandom;
    if (to) begin
      @(negedge gclk);
      check_output("hold_in_err", 32'(dwb_hold), 32'h0);
      @(posedge gclk); #1;
    end else if (wr) begin
      @(negedge gclk);
      check_output("rdat_after_store", rdat_mx, ref_rdat);
      @(posedge gclk); #1;
    end
  endtask

  // Monitor: every valid or error pulse must match the oldest expectation.
  always @(negedge gclk) begin
    if (grst && (rdat_vld || dwb_err)) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_pulse", 32'({dwb_err, rdat_vld}), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("err_flag", 32'(dwb_err), 32'(e.is_err));
        check_output("vld_flag", 32'(rdat_vld), 32'(!e.is_err));
        check_output("abt_flag", 32'(dwb_abt), 32'(e.is_err));
        check_output("rdat", rdat_mx, e.val);
      end
    end
  end

  initial begin
    logic [3:0] sels [11];
    sels = '{4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h5, 4'hA, 4'h6};
    ref_rdat = 32'h0;
    grst = 1'b0; dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_sel = 4'h0;
    dwb_ack_i = 1'b0; dwb_dat_i = 32'h0;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    check_output("rst_hold", 32'(dwb_hold), 32'h0);
    check_output("rst_abt", 32'(dwb_abt), 32'h0);
    check_output("rst_rdat", rdat_mx, 32'h0);
    check_output("rst_vld", 32'(rdat_vld), 32'h0);
    check_output("rst_err", 32'(dwb_err), 32'h0);
    @(posedge gclk); #1;
    grst = 1'b1;
    @(posedge gclk); #1;

    run_txn(1'b0, 4'hF, 32'hCAFEBABE, 0);
    repeat (3) @(posedge gclk);
    #1;
    run_txn(1'b0, 4'h8, 32'h11223344, 3);
    run_txn(1'b0, 4'h4, 32'h11223344, 3);
    run_txn(1'b0, 4'h2, 32'h11223344, 3);
    run_txn(1'b0, 4'h1, 32'h11223344, 3);
    run_txn(1'b0, 4'h3, 32'hA5A5BEEF, 1);
    run_txn(1'b1, 4'hF, 32'hDEADBEEF, 0);
    run_txn(1'b0, 4'hF, 32'h12345678, DTO + 1);
    dwb_ack_i = 1'b1;
    @(posedge gclk); #1;
    dwb_ack_i = 1'b0;
    run_txn(1'b0, 4'hC, 32'h89ABCDEF, DTO);

    // Reset during WAIT, with a pending ack left on the bus afterwards.
    dwb_stb = 1'b1; dwb_wre = 1'b0; dwb_sel = 4'hF; dwb_ack_i = 1'b0;
    repeat (2) @(posedge gclk);
    #2;
    grst = 1'b0; dwb_stb = 1'b0; dwb_ack_i = 1'b1;
    #1;
    ref_rdat = 32'h0;
    check_output("midrst_hold", 32'(dwb_hold), 32'h0);
    check_output("midrst_abt", 32'(dwb_abt), 32'h0);
    check_output("midrst_rdat", rdat_mx, 32'h0);
    check_output("midrst_vld", 32'(rdat_vld), 32'h0);
    check_output("midrst_err", 32'(dwb_err), 32'h0);
    @(posedge gclk); #1;
    grst = 1'b1;
    repeat (2) @(posedge gclk);
    #1;
    dwb_ack_i = 1'b0;
    run_txn(1'b0, 4'hF, 32'h0BADF00D, 2);

    for (int i = 0; i < 80; i++) begin
      int r, wt;
      r = $urandom_range(0, 9);
      if (r < 3)       wt = 0;
      else if (r == 9) wt = DTO + 1;
      else             wt = $urandom_range(1, DTO);
      run_txn(($urandom_range(0, 3) == 0), sels[$urandom_range(0, 10)], $urandom, wt);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge gclk); #1;
      end
    end

    repeat (3) @(posedge gclk);
    #1;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aemb2_dwb_rtn.md
# aemb2_dwb_rtn

Data-bus return stage of the AEMB2 core. It sits directly downstream of the data Wishbone interface. It watches the registered strobe/select/write-enable and the slave acknowledge, and holds the pipeline while a data cycle is outstanding. On read completion it captures and right-aligns the returned lanes into a zero-extended writeback word, and aborts with an error flag if a slave never acknowledges.

## Interface
Parameters:
- AEMB_DTO, 255, wait-cycle limit before timeout (1..255)

Ports:
- gclk  input  1  core clock, all flops on rising edge
- grst  input  1  reset, asynchronous, active-low
- dwb_stb  input  1  registered data strobe from the data bus interface
- dwb_wre  input  1  registered write-enable (1 = store)
- dwb_sel  input  4  registered byte-lane select; big-endian, 4'h8 = bits [31:24]
- dwb_ack_i  input  1  slave acknowledge
- dwb_dat_i  input  32  slave read data
- dwb_hold  output  1  pipeline hold; dena is gated low while set
- dwb_abt  output  1  request to drop stb/cyc (timeout abort), one cycle
- rdat_mx  output  32  aligned, zero-extended load result
- rdat_vld  output  1  one-cycle pulse: rdat_mx holds new load data
- dwb_err  output  1  one-cycle pulse: bus timeout

## Operation
- States: IDLE, WAIT, ERR (2-bit encoding in the package).
- **IDLE**:
  - stb=0 → stay.
  - stb=1 and ack=1 (zero-wait) → stay; for a read, capture and align; no hold.
  - stb=1 and ack=0 → WAIT; wait counter cleared to 1.
- **WAIT**:
  - ack=1 → IDLE; capture if read.
  - ack=0 with counter == AEMB_DTO → ERR.
  - Otherwise the counter increments (8 bits, saturating; never wraps).
- **ERR**:
  - Unconditionally → IDLE next cycle.
  - Any ack seen in ERR, or after the return to IDLE with stb=0, is discarded.
- dwb_hold is combinational: (state==WAIT & !ack) | (state==IDLE & stb & !ack).
- Reads (wre=0) are aligned from dwb_sel:
  - F → dat_i[31:0]
  - C → {16'h0, dat_i[31:16]}; 3 → {16'h0, dat_i[15:0]}
  - 8 → dat_i[31:24]; 4 → [23:16]; 2 → [15:8]; 1 → [7:0], each zero-extended
  - 0 (XSL) → dat_i passed unaligned
  - any other select → 32'h0, with rdat_vld still pulsed
- Writes (wre=1):
  - ack ends the wait.
  - rdat_mx is unchanged and rdat_vld stays 0.
- Timeout:
  - rdat_mx is forced to 32'h0.
  - dwb_err and dwb_abt pulse together for the single ERR cycle.
  - rdat_vld stays 0.
- Simultaneous ack and timeout in the same cycle: ack wins and the access completes normally.
- Reset mid-transaction:
  - state → IDLE, counter → 0, all outputs → 0.
  - A pending ack after reset release is ignored unless stb=1.

## Timing
- Reset values: dwb_hold 0, dwb_abt 0, rdat_mx 32'h0, rdat_vld 0, dwb_err 0.
- Load latency: rdat_mx and rdat_vld are registered and valid in the cycle after the ack cycle.
- Hold releases combinationally in the ack cycle, so dena rises in that cycle.
- Timeout:
  - stb rises at cycle 0 with no ack; hold is high through cycle AEMB_DTO.
  - ERR occupies cycle AEMB_DTO+1, with hold low and err/abt high.
- Back-to-back: a new stb in the cycle after an ack is accepted from IDLE with no bubble.

## Structure
- Package aemb2_dwb_pkg:
  - state enum IDLE/WAIT/ERR
  - select constants SEL_W, SEL_HI, SEL_LO, SEL_B0..SEL_B3, SEL_XSL
  - timeout counter width 8
- Sub-module aemb2_ld_align: purely combinational sel/data → aligned word. It is reused by the instruction-side XSL path.
- Top module: FSM, counter, output registers.

## Test plan
- Zero-wait word read: sel=F, ack with stb, dat=32'hCAFEBABE → hold never asserted; next cycle rdat_mx=CAFEBABE, rdat_vld=1 for exactly one cycle.
- Byte reads, 3-cycle wait each: dat=32'h11223344 with sel 8/4/2/1 → hold high 3 cycles; rdat_mx 0x11, 0x22, 0x33, 0x44 in turn.
- Halfword read, sel=3, dat=32'hA5A5BEEF → rdat_mx=32'h0000BEEF. Store, sel=F with ack → rdat_vld=0 and rdat_mx unchanged.
- Timeout with AEMB_DTO=4 and no ack → hold high cycles 0..4; err=abt=1 in cycle 5; rdat_mx=0. A late ack in cycle 6 with stb=0 → no rdat_vld.
- Ack exactly at counter==AEMB_DTO → normal completion, dwb_err stays 0.
- grst asserted low during WAIT (asynchronous, mid-cycle) → all outputs 0 immediately. After release, state is IDLE and the next read completes normally.
